fixed_ctrl: RTL and testbench

FIXED_CTRL -- requirements
Module: fixed_ctrl

---
 rtl/fixed_ctrl_pkg.sv | 6 +
 rtl/fixed_ctrl_cnt.sv | 18 +
 rtl/fixed_ctrl.sv | 113 +++++++++++
 tb/tb_fixed_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_ctrl_pkg.sv
// fixed_ctrl_pkg: state encoding and default timing constants shared by the fixed_ctrl block.
package fixed_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_e;
  localparam int INIT_CYC_DEF = 2;
  localparam int DRAIN_CYC_DEF = 3;
endpackage

// File: rtl/fixed_ctrl_cnt.sv
// fixed_ctrl_cnt: loadable down-counter with enable and zero flag, shared by INIT, RUN and DRAIN timing.
module fixed_ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = ld ? ld_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/fixed_ctrl.sv
// fixed_ctrl: init/run/drain sequencer for a fixed-latency unit.
// Optional run-cycle counter output enabled by FIXED_CTRL_CYCLE_CNT_EN.
module fixed_ctrl
  import fixed_ctrl_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int INIT_CYC  = INIT_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic             fixed_ctrl_clk,
  input  logic             fixed_ctrl_reset,
  input  logic             fixed_ctrl_start,
  input  logic [LEN_W-1:0] fixed_ctrl_len,
  input  logic             fixed_ctrl_stall,
  input  logic             fixed_ctrl_abort,
  output logic             fixed_ctrl_fu_init,
  output logic             fixed_ctrl_fu_in_disable,
  output logic             fixed_ctrl_busy,
`ifdef FIXED_CTRL_CYCLE_CNT_EN
  output logic             fixed_ctrl_done,
  output logic [LEN_W+7:0] fixed_ctrl_cycles
`else
  output logic             fixed_ctrl_done
`endif
);
  localparam logic [LEN_W-1:0] INIT_LD  = LEN_W'(INIT_CYC - 1);
  localparam logic [LEN_W-1:0] DRAIN_LD = LEN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, ld_val;
  logic             fu_init_q, fu_init_d, dis_q, dis_d, busy_q, busy_d, done_q, done_d;
  logic             ld, en, zero;
  // Counter is loaded with N-1 so the zero flag marks the last cycle of each phase.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ld      = 1'b0;
    ld_val  = '0;
    en      = 1'b0;
    case (state_q)
      IDLE: if (fixed_ctrl_start) begin
        state_d = (fixed_ctrl_len != '0) ? INIT : DONE;
        len_d   = fixed_ctrl_len;
        ld      = 1'b1;
        ld_val  = INIT_LD;
      end
      INIT: begin
        en = 1'b1;
        if (fixed_ctrl_abort) state_d = DONE;
        else if (zero) begin
          state_d = RUN;
          ld      = 1'b1;
          ld_val  = len_q - 1'b1;
        end
      end
      RUN: begin
        en = !fixed_ctrl_stall;
        if (fixed_ctrl_abort) state_d = DONE;
        else if (!fixed_ctrl_stall && zero) begin
          state_d = (DRAIN_CYC == 0) ? DONE : DRAIN;
          ld      = 1'b1;
          ld_val  = DRAIN_LD;
        end
      end
      DRAIN: begin
        en = 1'b1;
        if (fixed_ctrl_abort || zero) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    fu_init_d = state_d == INIT;
    dis_d     = state_d != DRAIN;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
  end
  always_ff @(posedge fixed_ctrl_clk or negedge fixed_ctrl_reset)
    if (!fixed_ctrl_reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      fu_init_q <= 1'b0;
      dis_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      fu_init_q <= fu_init_d;
      dis_q     <= dis_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  fixed_ctrl_cnt #(.W(LEN_W)) u_cnt (
    .clk    (fixed_ctrl_clk),
    .rst_n  (fixed_ctrl_reset),
    .ld     (ld),
    .ld_val (ld_val),
    .en     (en),
    .zero   (zero)
  );
  // Stall gates the unit directly while running so a stalled cycle is never consumed.
  assign fixed_ctrl_fu_in_disable = (state_q == RUN) ? fixed_ctrl_stall : dis_q;
  assign fixed_ctrl_fu_init       = fu_init_q;
  assign fixed_ctrl_busy          = busy_q;
  assign fixed_ctrl_done          = done_q;
`ifdef FIXED_CTRL_CYCLE_CNT_EN
  logic [LEN_W+7:0] cyc_q, cyc_d;
  always_comb cyc_d = (state_q == IDLE && fixed_ctrl_start) ? '0 :
                      (state_q inside {INIT, RUN, DRAIN} && ~&cyc_q) ? cyc_q + 1'b1 : cyc_q;
  always_ff @(posedge fixed_ctrl_clk or negedge fixed_ctrl_reset)
    if (!fixed_ctrl_reset) cyc_q <= '0;
    else cyc_q <= cyc_d;
  assign fixed_ctrl_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_fixed_ctrl.sv
// tb_fixed_ctrl: scoreboard bench for fixed_ctrl with default parameters.
module tb_fixed_ctrl;
  localparam int LEN_W = 16;
  typedef struct {int lat; int n_init; int n_en;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, abort = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic fu_init, fu_in_disable, busy, done;
  int total = 0, bad = 0;
  exp_t sb[$];
`ifdef FIXED_CTRL_CYCLE_CNT_EN
  logic [LEN_W+7:0] cycles;
`endif
  fixed_ctrl dut (
    .fixed_ctrl_clk           (clk),
    .fixed_ctrl_reset         (rst_n),
    .fixed_ctrl_start         (start),
    .fixed_ctrl_len           (len_i),
    .fixed_ctrl_stall         (stall),
    .fixed_ctrl_abort         (abort),
    .fixed_ctrl_fu_init       (fu_init),
    .fixed_ctrl_fu_in_disable (fu_in_disable),
    .fixed_ctrl_busy          (busy),
`ifdef FIXED_CTRL_CYCLE_CNT_EN
    .fixed_ctrl_done          (done),
    .fixed_ctrl_cycles        (cycles)
`else
    .fixed_ctrl_done          (done)
`endif
  );
  always #5 clk = ~clk;
  // Cycle 1 is the cycle start is presented; measurement stops two cycles after the first done.
  task automatic measure(input int len, input logic [127:0] stall_m, input int abort_c, input int budget,
                         output int lat, output int n_init, output int n_en, output int n_done,
                         output logic dis_at_done, output logic busy_after);
    lat = 0; n_init = 0; n_en = 0; n_done = 0; dis_at_done = 1'b0; busy_after = 1'b1;
    @(negedge clk);
    start = 1'b1; len_i = LEN_W'(len); stall = 1'b0; abort = 1'b0;
    for (int c = 2; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0; len_i = LEN_W'($urandom);
      stall = (c < 128) ? stall_m[c] : 1'b0;
      abort = (c == abort_c);
      #1;
      if (fu_init) n_init++;
      if (!fu_in_disable) n_en++;
      if (done) begin
        n_done++;
        if (lat == 0) begin lat = c; dis_at_done = fu_in_disable; end
      end
      if (lat != 0 && c == lat + 1) busy_after = busy;
      if (lat != 0 && c == lat + 2) break;
    end
    stall = 1'b0; abort = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    total += 4;
    if (fu_init !== 1'b0) begin bad++; $display("FAIL reset_fu_init got=%b want=0", fu_init); end
    if (fu_in_disable !== 1'b1) begin bad++; $display("FAIL reset_dis got=%b want=1", fu_in_disable); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
`ifdef FIXED_CTRL_CYCLE_CNT_EN
    total++;
    if (cycles !== '0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_basic;
    int lat, ni, ne, nd; logic dd, ba; exp_t e;
    sb.push_back('{11, 2, 7});
    measure(4, '0, 0, 40, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 5;
    if (lat !== e.lat) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, e.lat); end
    if (ni !== e.n_init) begin bad++; $display("FAIL basic_init_cycles got=%0d want=%0d", ni, e.n_init); end
    if (ne !== e.n_en) begin bad++; $display("FAIL basic_enabled_cycles got=%0d want=%0d", ne, e.n_en); end
    if (nd !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", nd); end
    if (ba !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", ba); end
  endtask
  task automatic test_stall;
    int lat, ni, ne, nd; logic dd, ba; exp_t e;
    logic [127:0] m = '0;
    m[5] = 1'b1; m[6] = 1'b1;
    sb.push_back('{14, 2, 8});
    measure(5, m, 0, 40, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 4;
    if (lat !== e.lat) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", lat, e.lat); end
    if (ni !== e.n_init) begin bad++; $display("FAIL stall_init_cycles got=%0d want=%0d", ni, e.n_init); end
    if (ne !== e.n_en) begin bad++; $display("FAIL stall_enabled_cycles got=%0d want=%0d", ne, e.n_en); end
    if (nd !== 1) begin bad++; $display("FAIL stall_done_pulses got=%0d want=1", nd); end
  endtask
  task automatic test_drain_stall;
    int lat, ni, ne, nd; logic dd, ba; exp_t e;
    logic [127:0] m = '0;
    m[7] = 1'b1;
    sb.push_back('{9, 2, 5});
    measure(2, m, 0, 40, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 2;
    if (lat !== e.lat) begin bad++; $display("FAIL drain_stall_latency got=%0d want=%0d", lat, e.lat); end
    if (ne !== e.n_en) begin bad++; $display("FAIL drain_stall_enabled got=%0d want=%0d", ne, e.n_en); end
  endtask
  task automatic test_len0;
    int lat, ni, ne, nd; logic dd, ba; exp_t e;
    sb.push_back('{2, 0, 0});
    measure(0, '0, 0, 20, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 4;
    if (lat !== e.lat) begin bad++; $display("FAIL len0_latency got=%0d want=%0d", lat, e.lat); end
    if (ni !== e.n_init) begin bad++; $display("FAIL len0_init_cycles got=%0d want=%0d", ni, e.n_init); end
    if (ne !== e.n_en) begin bad++; $display("FAIL len0_enabled_cycles got=%0d want=%0d", ne, e.n_en); end
    if (ba !== 1'b0) begin bad++; $display("FAIL len0_busy_after got=%b want=0", ba); end
`ifdef FIXED_CTRL_CYCLE_CNT_EN
    total++;
    if (cycles !== '0) begin bad++; $display("FAIL len0_cycles got=%0d want=0", cycles); end
`endif
  endtask
  task automatic test_abort;
    int lat, ni, ne, nd; logic dd, ba; exp_t e;
    sb.push_back('{14, 2, 10});
    measure(100, '0, 13, 200, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 5;
    if (lat !== e.lat) begin bad++; $display("FAIL abort_latency got=%0d want=%0d", lat, e.lat); end
    if (ne !== e.n_en) begin bad++; $display("FAIL abort_enabled_cycles got=%0d want=%0d", ne, e.n_en); end
    if (dd !== 1'b1) begin bad++; $display("FAIL abort_dis_at_done got=%b want=1", dd); end
    if (ba !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", ba); end
    if (nd !== 1) begin bad++; $display("FAIL abort_done_pulses got=%0d want=1", nd); end
  endtask
  task automatic test_reset_mid;
    int lat, ni, ne, nd, seen; logic dd, ba; exp_t e;
    @(negedge clk);
    start = 1'b1; len_i = 16'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || fu_in_disable !== 1'b0) begin
      bad++; $display("FAIL mid_running got busy=%b dis=%b want busy=1 dis=0", busy, fu_in_disable);
    end
    #1 rst_n = 1'b0;
    #1;
    total += 3;
    if (fu_in_disable !== 1'b1) begin bad++; $display("FAIL mid_reset_dis got=%b want=1", fu_in_disable); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
    if (fu_init !== 1'b0) begin bad++; $display("FAIL mid_reset_fu_init got=%b want=0", fu_init); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      #1 if (done) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL mid_reset_no_done got=%0d want=0", seen); end
    sb.push_back('{8, 2, 4});
    measure(1, '0, 0, 30, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 2;
    if (lat !== e.lat) begin bad++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, e.lat); end
    if (ne !== e.n_en) begin bad++; $display("FAIL post_reset_enabled got=%0d want=%0d", ne, e.n_en); end
  endtask
  task automatic test_cycles;
    int lat, ni, ne, nd; logic dd, ba; exp_t e;
    logic [127:0] m = '0;
    m[5] = 1'b1;
    sb.push_back('{11, 2, 6});
    measure(3, m, 0, 40, lat, ni, ne, nd, dd, ba);
    e = sb.pop_front();
    total += 2;
    if (lat !== e.lat) begin bad++; $display("FAIL cyc_run_latency got=%0d want=%0d", lat, e.lat); end
    if (ne !== e.n_en) begin bad++; $display("FAIL cyc_run_enabled got=%0d want=%0d", ne, e.n_en); end
`ifdef FIXED_CTRL_CYCLE_CNT_EN
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (cycles !== 24'd9) begin bad++; $display("FAIL cycles_held got=%0d want=9", cycles); end
`endif
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; len_i = '0;
    @(negedge clk);
    len_i = 16'd3;
    #1;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
    @(negedge clk);
    start = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done_busy got=%b want=0", busy); end
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || fu_init !== 1'b0) begin
      bad++; $display("FAIL b2b_ignored got busy=%b init=%b want 0 0", busy, fu_init);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drain_stall();
    test_len0();
    test_abort();
    test_reset_mid();
    test_cycles();
    test_back_to_back();
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
